// File: rtl/switch_allocator3.sv
// switch_allocator3: wormhole switch allocator for a three-port chain node.
// Port 0 is local, port 1 faces lower node IDs, port 2 faces higher node IDs.
// Each output is locked to one input from its head flit until the packet's
// tail flit has been transferred. Contention for an idle output is resolved
// by a per-output round-robin pointer.
module switch_allocator3 #(
  parameter logic [3:0] NODE_ID   = 4'd0,
  parameter int         NUM_PORTS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] in_valid,
  input  logic [15:0]          in_flit  [0:NUM_PORTS-1],
  output logic [NUM_PORTS-1:0] in_pop,
  input  logic [NUM_PORTS-1:0] out_full,
  output logic [NUM_PORTS-1:0] out_send,
  output logic [15:0]          out_flit [0:NUM_PORTS-1]
);

  // Per-input state: set while the input owns an output.
  logic [NUM_PORTS-1:0] bound;

  // Per-output state.
  logic [NUM_PORTS-1:0] locked;
  logic [1:0]           owner     [NUM_PORTS];
  logic [4:0]           remaining [NUM_PORTS];
  logic [1:0]           rr_ptr    [NUM_PORTS];

  // Combinational allocation signals.
  logic [1:0]           route     [NUM_PORTS];
  logic [NUM_PORTS-1:0] req       [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt_valid;
  logic [1:0]           gnt_idx   [NUM_PORTS];
  logic [NUM_PORTS-1:0] xfer;

  // Destination-ID routing on the linear chain.
  function automatic logic [1:0] route_of(input logic [3:0] dest);
    if (dest == NODE_ID)     return 2'd0;
    else if (dest < NODE_ID) return 2'd1;
    else                     return 2'd2;
  endfunction

  // Decode each head flit and raise requests from free, valid inputs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    for (int i = 0; i < NUM_PORTS; i++) begin
      route[i] = route_of(in_flit[i][15:12]);
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_valid[i] && !bound[i] && (route[i] == 2'(o))) begin
          req[o][i] = 1'b1;
        end
      end
    end
  end

  // Round-robin pick per output: first requester at or after the pointer.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt_valid[o] = 1'b0;
      gnt_idx[o]   = 2'd0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        idx = (int'(rr_ptr[o]) + k) % NUM_PORTS;
        if (req[o][idx]) begin
          gnt_valid[o] = 1'b1;
          gnt_idx[o]   = 2'(idx);
        end
      end
    end
  end

  // Pass-through datapath of locked outputs; pops and sends are forced low in reset.
  always_comb begin
    in_pop = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      xfer[o]     = 1'b0;
      out_flit[o] = '0;
      if (locked[o]) begin
        out_flit[o] = in_flit[owner[o]];
        xfer[o]     = in_valid[owner[o]] && !out_full[o] && !rst;
      end
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (xfer[o]) begin
        in_pop[owner[o]] = 1'b1;
      end
    end
    out_send = xfer;
  end

  // Lock on grant, count down the packet, release after the tail flit.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update in
    // this block sees the values from before the clock edge.
    if (rst) begin
      // NOTE: the per-output arrays are a handful of flops, not a memory, so
      // they are all reset to give a known allocator state after reset.
      bound  <= '0;
      locked <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        owner[o]     <= 2'd0;
        remaining[o] <= 5'd0;
        rr_ptr[o]    <= 2'd0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (!locked[o]) begin
          if (gnt_valid[o]) begin
            locked[o]         <= 1'b1;
            owner[o]          <= gnt_idx[o];
            remaining[o]      <= 5'(in_flit[gnt_idx[o]][11:8]) + 5'd1;
            rr_ptr[o]         <= (gnt_idx[o] == 2'(NUM_PORTS - 1)) ? 2'd0 : gnt_idx[o] + 2'd1;
            bound[gnt_idx[o]] <= 1'b1;
          end
        end else if (xfer[o]) begin
          remaining[o] <= remaining[o] - 5'd1;
          if (remaining[o] == 5'd1) begin
            locked[o]       <= 1'b0;
            bound[owner[o]] <= 1'b0;
          end
        end
      end
    end
  end

endmodule
